// File: rtl/srv_icache_refill.sv
// srv_icache_refill: I-cache line-refill engine. It takes one refill request,
// issues LINE_WORDS word reads on a pipelined req/gnt/rvalid bus, builds the
// line from the returned words and gives the line back with a one-cycle rsp_o.
module srv_icache_refill #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_i,
    input  logic [31:0]              line_addr_i,
    output logic                     rsp_o,
    output logic [32*LINE_WORDS-1:0] line_data_o,
    output logic                     busy_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i
);

    localparam int unsigned CW = $clog2(LINE_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             base_q;
    logic [CW-1:0]           icnt_q, icnt_d;
    logic [CW-1:0]           rcnt_q, rcnt_d;
    logic [CW-1:0]           outst;
    logic                    issue;
    logic                    capture;

    // Bus-side outputs and beat/capture qualifiers derived from the current state.
    always_comb begin
        outst      = icnt_q - rcnt_q;
        mem_req_o  = (state_q == S_ISSUE) && (outst < CW'(MAX_OUTST));
        mem_addr_o = (state_q == S_ISSUE) ? (base_q + 32'(icnt_q)) : '0;
        issue      = mem_req_o & mem_gnt_i;
        capture    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                     mem_rvalid_i && (rcnt_q < CW'(LINE_WORDS));
        rsp_o      = (state_q == S_RESP);
        busy_o     = (state_q != S_IDLE);
    end

    // Next-state and counter update; completion takes priority over the WAIT move.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_ISSUE;
                    icnt_d  = '0;
                    rcnt_d  = '0;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (issue) begin
                    icnt_d = icnt_q + 1'b1;
                end
                if (capture) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
                if (capture && (rcnt_d == CW'(LINE_WORDS))) begin
                    state_d = S_RESP;
                end else if ((state_q == S_ISSUE) && (icnt_d == CW'(LINE_WORDS))) begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, latched base address and the assembled line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            icnt_q      <= '0;
            rcnt_q      <= '0;
            base_q      <= '0;
            line_data_o <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
            if ((state_q == S_IDLE) && req_i) begin
                base_q <= line_addr_i & ~32'h3;
            end
            if (capture) begin
                line_data_o[32*rcnt_q +: 32] <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_srv_icache_refill.sv
// Directed bench for srv_icache_refill: a vector table of single refills run
// against two instances (MAX_OUTST=4 and MAX_OUTST=1) behind a small memory
// model, plus hand sequences for reset mid-refill and back-to-back requests.
module tb_srv_icache_refill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] line_addr = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;

    logic         req0, req1, gnt0, gnt1, rv0, rv1;
    logic         rsp0, rsp1, busy0, busy1, mreq0, mreq1;
    logic [31:0]  maddr0, maddr1;
    logic [127:0] line0, line1;
    logic         rsp, busy, mreq;
    logic [31:0]  maddr;
    logic [127:0] line;

    always #5 clk = ~clk;

    assign req0 = req & ~sel;
    assign req1 = req & sel;
    assign gnt0 = gnt & ~sel;
    assign gnt1 = gnt & sel;
    assign rv0  = rvalid & ~sel;
    assign rv1  = rvalid & sel;
    assign rsp   = sel ? rsp1   : rsp0;
    assign busy  = sel ? busy1  : busy0;
    assign mreq  = sel ? mreq1  : mreq0;
    assign maddr = sel ? maddr1 : maddr0;
    assign line  = sel ? line1  : line0;

    srv_icache_refill #(.LINE_WORDS(4), .MAX_OUTST(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .line_addr_i(line_addr),
        .rsp_o(rsp0), .line_data_o(line0), .busy_o(busy0),
        .mem_req_o(mreq0), .mem_addr_o(maddr0), .mem_gnt_i(gnt0),
        .mem_rvalid_i(rv0), .mem_rdata_i(rdata)
    );

    srv_icache_refill #(.LINE_WORDS(4), .MAX_OUTST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req1), .line_addr_i(line_addr),
        .rsp_o(rsp1), .line_data_o(line1), .busy_o(busy1),
        .mem_req_o(mreq1), .mem_addr_o(maddr1), .mem_gnt_i(gnt1),
        .mem_rvalid_i(rv1), .mem_rdata_i(rdata)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } beat_t;

    beat_t        pend[$];
    logic [31:0]  glog[$];
    int unsigned  rlog[$];
    logic [127:0] llog[$];
    int unsigned  cyc = 0;
    int unsigned  stall_n = 0;
    int unsigned  stall_c = 0;
    int unsigned  dly = 1;
    bit           force_rv = 1'b0;
    bit           prev_stall = 1'b0;
    logic [31:0]  prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and bus monitor: drives gnt/rvalid/rdata for the selected instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            gnt        = 1'b0;
            rvalid     = 1'b0;
            prev_stall = 1'b0;
            stall_c    = 0;
        end else begin
            if (prev_stall) chk("addr_stable", {mreq, maddr}, {1'b1, prev_addr});
            if (sel && (pend.size() > 0)) chk("outst_block", mreq, 1'b0);
            if (force_rv) begin
                rvalid = 1'b1;
                rdata  = 32'hDEAD_BEEF;
            end else if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
                rvalid = 1'b1;
                rdata  = pend[0].addr + 32'hA0;
                void'(pend.pop_front());
            end else begin
                rvalid = 1'b0;
            end
            gnt = 1'b0;
            if (mreq) begin
                if (stall_c < stall_n) begin
                    stall_c++;
                end else begin
                    gnt     = 1'b1;
                    stall_c = 0;
                    glog.push_back(maddr);
                    pend.push_back('{maddr, cyc + dly});
                end
            end
            prev_stall = mreq && !gnt;
            prev_addr  = maddr;
            if (rsp) begin
                rlog.push_back(cyc);
                llog.push_back(line);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0]  addr;
        int unsigned  stall;
        int unsigned  dly;
        bit           sel;
        logic [127:0] line;
        int unsigned  lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int unsigned t0;
        logic [31:0] base;
        base    = v.addr & ~32'h3;
        sel     = v.sel;
        stall_n = v.stall;
        dly     = v.dly;
        glog.delete();
        rlog.delete();
        llog.delete();
        tick();
        req       = 1'b1;
        line_addr = v.addr;
        t0        = cyc;
        tick();
        req       = 1'b0;
        line_addr = 32'h5555_5555;
        for (int i = 0; (i < 200) && (rlog.size() == 0); i++) tick();
        if (rlog.size() == 0) begin
            chk("rsp_timeout", 1'b0, 1'b1);
            return;
        end
        chk("latency", rlog[0] - t0, v.lat);
        chk("line", llog[0], v.line);
        chk("n_grants", glog.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) chk("gnt_addr", glog[k], base + 32'(k));
        end
        tick();
        chk("hold_busy", {busy, rsp}, 2'b10);
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("one_rsp", rlog.size(), 1);
        chk("line_held", line, v.line);
    endtask

    vec_t vtab[6];

    initial begin
        vtab[0] = '{32'h0000_0104, 0, 1, 1'b0, {32'h1A7, 32'h1A6, 32'h1A5, 32'h1A4}, 6};
        vtab[1] = '{32'h0000_0013, 0, 1, 1'b0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 6};
        vtab[2] = '{32'h0000_0500, 3, 1, 1'b0, {32'h5A3, 32'h5A2, 32'h5A1, 32'h5A0}, 18};
        vtab[3] = '{32'h0000_0620, 0, 5, 1'b1, {32'h6C3, 32'h6C2, 32'h6C1, 32'h6C0}, 25};
        vtab[4] = '{32'hFFFF_FFFE, 0, 1, 1'b1, {32'h9F, 32'h9E, 32'h9D, 32'h9C}, 9};
        vtab[5] = '{32'h0000_0700, 2, 3, 1'b0, {32'h7A3, 32'h7A2, 32'h7A1, 32'h7A0}, 16};

        // Reset values on both instances.
        tick();
        tick();
        chk("rst_outs0", {rsp0, busy0, mreq0, maddr0, line0}, '0);
        chk("rst_outs1", {rsp1, busy1, mreq1, maddr1, line1}, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vtab[i]);

        // Reset after the second grant, then stray rvalid in IDLE, then a new refill.
        sel     = 1'b0;
        stall_n = 0;
        dly     = 3;
        glog.delete();
        rlog.delete();
        llog.delete();
        tick();
        req       = 1'b1;
        line_addr = 32'h40;
        tick();
        req = 1'b0;
        for (int i = 0; (i < 20) && (glog.size() < 2); i++) tick();
        chk("pre_rst_grants", glog.size(), 2);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {rsp, busy, mreq, maddr, line}, '0);
        tick();
        tick();
        chk("mid_rst_hold", {rsp, busy, mreq, maddr, line}, '0);
        rst_n    = 1'b1;
        force_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_rv", {busy, line}, '0);
        end
        force_rv = 1'b0;
        tick();
        chk("rst_no_rsp", rlog.size(), 0);
        run_vec('{32'h0000_0080, 0, 1, 1'b0, {32'h123, 32'h122, 32'h121, 32'h120}, 6});

        // Back-to-back: req held 20 cycles, address changed while in ISSUE.
        begin
            int unsigned t0;
            sel     = 1'b0;
            stall_n = 0;
            dly     = 1;
            glog.delete();
            rlog.delete();
            llog.delete();
            tick();
            req       = 1'b1;
            line_addr = 32'h200;
            t0        = cyc;
            tick();
            tick();
            line_addr = 32'h300;
            for (int i = 2; i < 20; i++) tick();
            req = 1'b0;
            for (int i = 0; (i < 40) && ((rlog.size() < 3) || busy); i++) tick();
            chk("b2b_nrsp", rlog.size(), 3);
            chk("b2b_ngnt", glog.size(), 12);
            if (rlog.size() == 3) begin
                chk("b2b_rsp1_t", rlog[0] - t0, 6);
                chk("b2b_rsp2_t", rlog[1] - t0, 14);
                chk("b2b_line1", llog[0], {32'h2A3, 32'h2A2, 32'h2A1, 32'h2A0});
                chk("b2b_line2", llog[1], {32'h3A3, 32'h3A2, 32'h3A1, 32'h3A0});
            end
            if (glog.size() == 12) begin
                for (int k = 0; k < 4; k++) begin
                    chk("b2b_addr1", glog[k], 32'h200 + 32'(k));
                    chk("b2b_addr2", glog[k+4], 32'h300 + 32'(k));
                end
            end
            chk("b2b_idle", busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
